calc_seq_ctrl: RTL
==================

Name: calc_seq_ctrl

Overview:
Parametrised sequencing controller for the calculator datapath: first operand entry, operator latch, second operand entry, ALU execution with start/done handshake, result display, operator chaining and error recovery. Sits between the debounced keypad pulses and the operand registers/ALU. Adds per-operand digit counting with overflow guard, backspace, a configurable operator code width, an ALU completion timeout and a sticky error state.

Parameters:
MAX_DIGITS, 4, maximum digits accepted per operand (>=1)
OP_W, 3, width of operator code (2 gives +,-,*,/; 3 adds codes 4..7 for extended ops)
TIMEOUT, 255, cycles to wait in S_WAIT for alu_done before forcing error (>=1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
esc  in  1  single-cycle clear pulse
digit_valid  in  1  single-cycle digit-key pulse (digit value goes directly to the datapath)
bksp  in  1  single-cycle backspace pulse
op_valid  in  1  single-cycle operator-key pulse
op_code  in  OP_W  operator code, sampled when op_valid=1
enter  in  1  single-cycle Enter pulse
alu_done  in  1  ALU result-valid pulse
alu_err  in  1  ALU error flag, qualified by alu_done (e.g. divide by zero)
current_state  out  3  encoded FSM state
calcul  out  OP_W  latched operator code
digit_cnt  out  $clog2(MAX_DIGITS+1)  digits in current operand
load_a  out  1  pulse: shift accepted digit into operand A
load_b  out  1  pulse: shift accepted digit into operand B
del_digit  out  1  pulse: drop last digit of active operand
chain  out  1  pulse: copy result into operand A
alu_start  out  1  one-cycle ALU start pulse
err  out  1  high while in S_ERROR

Behaviour:
- Reset (async, rst_n=0): state=S_FIRST, calcul=0, digit_cnt=0, all pulse outputs 0, err=0, timer=0. All outputs are registered.
- Encoding: S_FIRST=0, S_OP=1, S_SECOND=2, S_EXEC=3, S_WAIT=4, S_RESULT=5, S_ERROR=6. Value 7 is illegal and recovers to S_FIRST on the next clock.
- Same-cycle input priority: esc > enter > op_valid > bksp > digit_valid. Lower-priority pulses in the same cycle are dropped.
- esc, in any state: next state S_FIRST, digit_cnt=0, calcul=0, err=0, no pulses.
- S_FIRST:
  - digit_valid with digit_cnt<MAX_DIGITS: load_a=1, digit_cnt+1.
  - digit_valid at MAX_DIGITS: ignored, no pulse.
  - bksp with digit_cnt>0: del_digit=1, digit_cnt-1. bksp at 0 is ignored.
  - op_valid: calcul<=op_code, go to S_OP. An empty operand A is legal and means value 0.
  - enter: ignored.
- S_OP: one cycle. digit_cnt<=0, go to S_SECOND. All inputs except esc are ignored.
- S_SECOND:
  - Digit and bksp rules as in S_FIRST, but digits drive load_b.
  - op_valid: calcul<=op_code (operator replace), stay in S_SECOND, digit_cnt unchanged.
  - enter with digit_cnt>0: go to S_EXEC. enter with digit_cnt=0: ignored.
- S_EXEC: alu_start=1 for exactly this cycle. Clear timer, go to S_WAIT.
- S_WAIT:
  - alu_done&!alu_err: go to S_RESULT.
  - alu_done&alu_err: go to S_ERROR.
  - Otherwise timer+1. When timer reaches TIMEOUT-1 without done, go to S_ERROR.
  - Other key inputs except esc are ignored.
- S_RESULT:
  - op_valid: chain=1, calcul<=op_code, go to S_OP (result becomes operand A).
  - digit_valid: start a new calculation; load_a=1, digit_cnt=1, go to S_FIRST.
  - enter, bksp: ignored.
- S_ERROR: err=1. Only esc exits. All other inputs are ignored.
- calcul changes only on an accepted op_valid or on esc/reset.
- Pulse outputs are asserted in the cycle after the triggering input (1-cycle latency). They are never high for more than one consecutive cycle from a single input pulse.
- digit_cnt saturates at MAX_DIGITS and never underflows below 0.
- Reset asserted mid-S_WAIT: controller returns to S_FIRST immediately. A late alu_done after reset is ignored.

Test Plan:
- Reset, 2 digits, op_valid op_code=2, 3 digits, enter, alu_done 4 cycles later -> load_a x2, calcul=2, load_b x3, alu_start single pulse, state 3->4->5, err=0.
- MAX_DIGITS=4: 6 digit pulses in S_FIRST -> exactly 4 load_a pulses, digit_cnt=4. Then 5 bksp -> 4 del_digit pulses, digit_cnt=0.
- In S_SECOND: op_valid op_code=1 then op_code=3 -> calcul=3, state stays 2. enter with digit_cnt=0 -> no alu_start.
- Execute with alu_done&alu_err=1 -> state 6, err=1. digit/enter/op ignored. esc -> state 0, calcul=0, err=0.
- TIMEOUT=8, no alu_done -> S_ERROR exactly 8 cycles after entering S_WAIT. Separately, in S_RESULT op_valid op_code=0 -> chain pulse, state 1 then 2, digit_cnt=0.
- Same-cycle enter+digit_valid in S_SECOND -> go to S_EXEC, no load_b. Same-cycle esc+op_valid -> S_FIRST, calcul=0. rst_n low mid-S_WAIT -> state=0 asynchronously.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: operand entry, operator latch, ALU handshake,
// result chaining, timeout and sticky error handling. All outputs are registered.
module calc_seq_ctrl #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned OP_W       = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            esc,
  input  logic                            digit_valid,
  input  logic                            bksp,
  input  logic                            op_valid,
  input  logic [OP_W-1:0]                 op_code,
  input  logic                            enter,
  input  logic                            alu_done,
  input  logic                            alu_err,
  output logic [2:0]                      current_state,
  output logic [OP_W-1:0]                 calcul,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_cnt,
  output logic                            load_a,
  output logic                            load_b,
  output logic                            del_digit,
  output logic                            chain,
  output logic                            alu_start,
  output logic                            err
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FIRST  = 3'd0,
    S_OP     = 3'd1,
    S_SECOND = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_RESULT = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] calcul_d;
  logic [CW-1:0]   cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            load_a_d, load_b_d, del_d, chain_d, start_d, err_d;
  logic            cnt_full, cnt_empty;

  assign cnt_full      = (digit_cnt == CW'(MAX_DIGITS));
  assign cnt_empty     = (digit_cnt == '0);
  assign current_state = state_q;

  // Only the highest-priority key pulse is examined; if the state ignores it,
  // the lower-priority pulses in that cycle are dropped as well.
  always_comb begin
    state_d  = state_q;
    calcul_d = calcul;
    cnt_d    = digit_cnt;
    timer_d  = timer_q;
    load_a_d = 1'b0;
    load_b_d = 1'b0;
    del_d    = 1'b0;
    chain_d  = 1'b0;
    if (esc) begin
      state_d  = S_FIRST;
      cnt_d    = '0;
      calcul_d = '0;
    end else begin
      case (state_q)
        S_FIRST, S_SECOND: begin
          if (enter) begin
            if (state_q == S_SECOND && !cnt_empty) state_d = S_EXEC;
          end else if (op_valid) begin
            calcul_d = op_code;
            if (state_q == S_FIRST) state_d = S_OP;
          end else if (bksp) begin
            if (!cnt_empty) begin
              del_d = 1'b1;
              cnt_d = digit_cnt - CW'(1);
            end
          end else if (digit_valid && !cnt_full) begin
            load_a_d = (state_q == S_FIRST);
            load_b_d = (state_q == S_SECOND);
            cnt_d    = digit_cnt + CW'(1);
          end
        end
        S_OP: begin
          cnt_d   = '0;
          state_d = S_SECOND;
        end
        S_EXEC: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) state_d = alu_err ? S_ERROR : S_RESULT;
          else if (timer_q == TW'(TIMEOUT - 1)) state_d = S_ERROR;
          else timer_d = timer_q + TW'(1);
        end
        S_RESULT: begin
          if (enter) begin
            state_d = S_RESULT;
          end else if (op_valid) begin
            chain_d  = 1'b1;
            calcul_d = op_code;
            state_d  = S_OP;
          end else if (bksp) begin
            state_d = S_RESULT;
          end else if (digit_valid) begin
            load_a_d = 1'b1;
            cnt_d    = CW'(1);
            state_d  = S_FIRST;
          end
        end
        S_ERROR: state_d = S_ERROR;
        default: begin
          state_d = S_FIRST;
          cnt_d   = '0;
        end
      endcase
    end
    start_d = (state_d == S_EXEC);
    err_d   = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FIRST;
      calcul    <= '0;
      digit_cnt <= '0;
      timer_q   <= '0;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      del_digit <= 1'b0;
      chain     <= 1'b0;
      alu_start <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      calcul    <= calcul_d;
      digit_cnt <= cnt_d;
      timer_q   <= timer_d;
      load_a    <= load_a_d;
      load_b    <= load_b_d;
      del_digit <= del_d;
      chain     <= chain_d;
      alu_start <= start_d;
      err       <= err_d;
    end
  end

endmodule
